// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/stall/write-back controller for the multi-cycle RV32M divider
module div_issue_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic [2:0]    funct3_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    input  logic [4:0]    rd_i,
    input  logic          flush_i,
    output logic          div_en_o,
    output logic [DW-1:0] div_dvd_o,
    output logic [DW-1:0] div_dvs_o,
    output logic          div_sgn_o,
    input  logic [DW-1:0] div_quot_i,
    input  logic [DW-1:0] div_rem_i,
    input  logic          div_done_i,
    input  logic          div_busy_i,
    output logic          stall_o,
    output logic          wb_en_o,
    output logic [4:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic          err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dvd_q, dvs_q, res_q, res_d;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [CW-1:0]   cnt_q;
    logic            latch;
    logic            err;
    logic            req_ok;
    logic            div_zero;
    logic            sgn_ovf;
    logic            timeout;
    logic            unused_busy;

    // Busy is informational only; completion is tracked by div_done_i.
    assign unused_busy = div_busy_i;

    assign req_ok   = req_valid_i & funct3_i[2];
    assign div_zero = (rs2_i == '0);
    assign sgn_ovf  = ~funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
    // >= so a counter that ran past the limit in WAIT still aborts DRAIN.
    assign timeout  = (cnt_q >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (latch) begin
                dvd_q <= rs1_i;
                dvs_q <= rs2_i;
                rd_q  <= rd_i;
                f3_q  <= funct3_i;
            end
            if (state_q == S_ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == S_WAIT || state_q == S_DRAIN) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        latch   = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok && !flush_i) begin
                    latch = 1'b1;
                    if (div_zero) begin
                        res_d   = funct3_i[1] ? rs1_i : ALL_ONES;
                        state_d = S_DONE;
                    end else if (sgn_ovf) begin
                        res_d   = funct3_i[1] ? '0 : rs1_i;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // The start strobe is already out this cycle, so a flush must drain.
                state_d = flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = div_done_i ? S_IDLE : S_DRAIN;
                end else if (div_done_i) begin
                    res_d   = f3_q[1] ? div_rem_i : div_quot_i;
                    state_d = S_DONE;
                end else if (timeout) begin
                    err     = 1'b1;
                    res_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (div_done_i) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign div_en_o  = (state_q == S_ISSUE);
    assign div_dvd_o = dvd_q;
    assign div_dvs_o = dvs_q;
    assign div_sgn_o = ~f3_q[0] &&
                       (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_DRAIN);
    assign stall_o   = (state_q == S_IDLE && req_ok) || state_q == S_ISSUE ||
                       state_q == S_WAIT || state_q == S_DRAIN;
    assign wb_en_o   = (state_q == S_DONE) && (rd_q != 5'd0) && !flush_i;
    assign wb_rd_o   = (state_q == S_DONE) ? rd_q : 5'd0;
    assign wb_data_o = (state_q == S_DONE) ? res_q : '0;
    assign err_o     = err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed-vector bench for div_issue_ctrl with a scripted divider stub
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        div_en_o;
    logic [31:0] div_dvd_o, div_dvs_o;
    logic        div_sgn_o;
    logic [31:0] div_quot_i, div_rem_i;
    logic        div_done_i;
    logic        div_busy_i;
    logic        stall_o;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    div_issue_ctrl #(.DW(32), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .funct3_i   (funct3_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .div_en_o   (div_en_o),
        .div_dvd_o  (div_dvd_o),
        .div_dvs_o  (div_dvs_o),
        .div_sgn_o  (div_sgn_o),
        .div_quot_i (div_quot_i),
        .div_rem_i  (div_rem_i),
        .div_done_i (div_done_i),
        .div_busy_i (div_busy_i),
        .stall_o    (stall_o),
        .wb_en_o    (wb_en_o),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    // lat = cycles from the start strobe to div_done_i (0 = never answer).
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] q,
                         input logic [31:0] r, input int lat, input logic exp_wb,
                         input logic [31:0] exp_data, input int exp_cyc, input int exp_en,
                         input int exp_err);
        int en_cnt  = 0;
        int en_cyc  = 0;
        int err_cnt = 0;
        int fin_cyc = -1;
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = f3;
        rs1_i       = a;
        rs2_i       = b;
        rd_i        = rd;
        div_quot_i  = q;
        div_rem_i   = r;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (div_en_o) begin
                en_cnt++;
                en_cyc = n;
                chk({tag, " dvd"}, div_dvd_o, a);
                chk({tag, " dvs"}, div_dvs_o, b);
                chk({tag, " sgn"}, {31'b0, div_sgn_o}, {31'b0, ~f3[0]});
            end
            if (err_o) err_cnt++;
            if (!stall_o) begin
                fin_cyc = n;
                chk({tag, " wb_en"}, {31'b0, wb_en_o}, {31'b0, exp_wb});
                if (exp_wb) chk({tag, " wb_rd"}, {27'b0, wb_rd_o}, {27'b0, rd});
                chk({tag, " wb_data"}, wb_data_o, exp_data);
                break;
            end
            div_done_i = (lat > 0) && (en_cnt > 0) && (n == en_cyc + lat);
            @(negedge clk);
        end
        chk({tag, " latency"}, fin_cyc, exp_cyc);
        chk({tag, " en_pulses"}, en_cnt, exp_en);
        chk({tag, " err_pulses"}, err_cnt, exp_err);
        req_valid_i = 1'b0;
        div_done_i  = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " idle_after"}, {31'b0, stall_o | wb_en_o}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b0;
        funct3_i    = 3'b000;
        rs1_i       = '0;
        rs2_i       = '0;
        rd_i        = '0;
        flush_i     = 1'b0;
        div_quot_i  = '0;
        div_rem_i   = '0;
        div_done_i  = 1'b0;
        div_busy_i  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst stall", {31'b0, stall_o}, 32'd0);
        chk("rst div_en", {31'b0, div_en_o}, 32'd0);
        chk("rst wb_en", {31'b0, wb_en_o}, 32'd0);
        chk("rst wb_data", wb_data_o, 32'd0);
        chk("rst dvd", div_dvd_o, 32'd0);
        chk("rst err", {31'b0, err_o}, 32'd0);
        rst = 1'b0;

        do_op("divu 100/7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 32'd2, 4, 1'b1, 32'd14, 6, 1, 0);
        do_op("remu 100/7", 3'b111, 32'd100, 32'd7, 5'd5, 32'd14, 32'd2, 4, 1'b1, 32'd2, 6, 1, 0);
        do_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3,
              1'b1, 32'hFFFF_FFFD, 5, 1, 0);
        do_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3,
              1'b1, 32'hFFFF_FFFF, 5, 1, 0);
        do_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'd0, 32'd0, 0,
              1'b1, 32'h8000_0000, 1, 0, 0);
        do_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'd0, 32'd0, 0,
              1'b1, 32'd0, 1, 0, 0);
        do_op("divu 5/0", 3'b101, 32'd5, 32'd0, 5'd4, 32'd0, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 1, 0, 0);
        do_op("rem 5/0", 3'b110, 32'd5, 32'd0, 5'd4, 32'd0, 32'd0, 0, 1'b1, 32'd5, 1, 0, 0);

        // Flush three cycles into WAIT: drain until the divider answers, never write back.
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = 3'b101;
        rs1_i       = 32'd100;
        rs2_i       = 32'd7;
        rd_i        = 5'd5;
        #1 chk("flush req stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        #1 chk("flush issue", {31'b0, div_en_o}, 32'd1);
        repeat (3) @(negedge clk);
        flush_i     = 1'b1;
        req_valid_i = 1'b0;
        #1 chk("flush cycle stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0;
        #1 chk("drain stall", {31'b0, stall_o}, 32'd1);
        chk("drain wb_en", {31'b0, wb_en_o}, 32'd0);
        @(negedge clk);
        div_quot_i = 32'd14;
        div_done_i = 1'b1;
        #1 chk("drain done stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        div_done_i = 1'b0;
        #1 chk("post drain stall", {31'b0, stall_o}, 32'd0);
        chk("post drain wb_en", {31'b0, wb_en_o}, 32'd0);
        do_op("divu 9/3", 3'b101, 32'd9, 32'd3, 5'd6, 32'd3, 32'd0, 3, 1'b1, 32'd3, 5, 1, 0);

        do_op("timeout", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 32'd2, 0, 1'b1, 32'd0, 66, 1, 1);
        do_op("rd zero", 3'b101, 32'd10, 32'd2, 5'd0, 32'd5, 32'd0, 2, 1'b0, 32'd5, 4, 1, 0);

        // Reset while waiting on the divider aborts silently.
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = 3'b100;
        rs1_i       = 32'd50;
        rs2_i       = 32'd5;
        rd_i        = 5'd2;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        req_valid_i = 1'b0;
        #1 chk("rst wait stall", {31'b0, stall_o}, 32'd0);
        chk("rst wait err", {31'b0, err_o}, 32'd0);
        @(negedge clk);
        #1 chk("rst wait wb_en", {31'b0, wb_en_o}, 32'd0);

        // Non-divide funct3: no stall, no issue.
        @(negedge clk);
        req_valid_i = 1'b1;
        funct3_i    = 3'b011;
        #1 chk("bad f3 stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        #1 chk("bad f3 div_en", {31'b0, div_en_o | wb_en_o}, 32'd0);
        req_valid_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
